md_iter_divider: RTL and testbench
==================================

Name: md_iter_divider

Overview:
Multicycle shift-subtract divider that sits under the E-stage multiply/divide unit. It replaces the single-cycle behavioural divide and drives that unit's busy/stall accounting. It accepts one DIV/DIVU request, iterates one quotient bit per cycle, and returns the quotient (LO) and remainder (HI) with a one-cycle done pulse. The parent unit holds hi/lo writes until done.

Parameters:
WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
start  input  1  request pulse; sampled only in IDLE
is_signed  input  1  1 = DIV semantics, 0 = DIVU; captured with start
dividend  input  WIDTH  rs value; captured with start
divisor  input  WIDTH  rt value; captured with start
cancel  input  1  exception flush; aborts an in-flight operation
busy  output  1  high in RUN and FIX
done  output  1  one-cycle pulse; results valid
quotient  output  WIDTH  destined for LO; held until next done
remainder  output  WIDTH  destined for HI; held until next done
div_by_zero  output  1  divisor was 0 for the last completed op; held with results

Behaviour:
- Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; counter and internal registers cleared. Reset overrides start and cancel and wins mid-operation.
- States: IDLE, RUN, FIX.
  - IDLE -> RUN on start=1: latch the magnitudes of the operands (two's-complement absolute value only when is_signed). Latch the sign flags and the raw dividend. Clear the partial remainder. Set counter=WIDTH.
  - RUN, one step per edge: shift {partial remainder, dividend magnitude} left by 1; trial subtract the divisor magnitude; if the result is non-negative, keep the difference and set quotient LSB=1, else 0. Decrement the counter. At the step where counter reaches 0, go to FIX.
  - FIX (one edge): apply signs, register the outputs, assert done for the following cycle, go to IDLE.
- Latency: start sampled at edge E0; RUN covers E1..E32; FIX is at E33. done=1 and results are valid in the cycle after E33. busy=1 from after E0 through the cycle before E33's effect ends, i.e. exactly 33 cycles.
- done is a single-cycle pulse. It is low in every other cycle.
- Sign rules (is_signed=1): the quotient is negated iff the operand signs differ. The remainder takes the sign of the dividend. Magnitude arithmetic uses WIDTH+1 bits so that the most negative value is handled.
- Divide by zero: the divider still runs its full latency. Result is quotient=all ones and remainder=raw dividend, for both signed and unsigned. div_by_zero=1.
- Overflow, signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, div_by_zero=0.
- start while busy: ignored. There is no queueing, and captured operands are unaffected.
- start in the done cycle: accepted, since the state is IDLE. done still pulses for the previous op, and busy rises next cycle.
- cancel in RUN or FIX: next state is IDLE, busy=0, no done pulse. quotient, remainder and div_by_zero keep their previous completed values.
- cancel in IDLE: no effect. If start and cancel are both high in IDLE, start is ignored.
- Outputs change only at FIX, and at reset.

Decomposition:
- Shared constants header: state encodings (IDLE/RUN/FIX), DIV_CYCLES = WIDTH+1, and the divide-by-zero result constant.
- No sub-module is required. Sign handling (abs/negate) is inline logic in the same file.

Test Plan:
- Unsigned 100/7: start at E0 -> done exactly in the cycle after E33; quotient=14, remainder=2, div_by_zero=0; busy high for 33 cycles.
- Signed -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7/-2 -> quotient=0xFFFFFFFD, remainder=1. Unsigned 0xFFFFFFF9/2 -> quotient=0x7FFFFFFC, remainder=1.
- Divide by zero: signed 5/0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. The next op, 9/3, clears the flag and returns quotient=3, remainder=0.
- Edge operands: signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned, same operands -> quotient=0, remainder=0x80000000.
- Abort: complete 100/7, then start 50/5 and assert cancel at RUN step 10 -> busy=0 next cycle, no done, outputs stay 14/2. Repeat with reset instead -> all outputs 0.
- Handshake: start pulses during busy are ignored (results match the first op). A start on the done cycle of 100/7 with 20/6 -> second done exactly 33 cycles later with quotient=3, remainder=2.

Source files
------------

// File: rtl/md_iter_divider_pkg.sv
// Shared definitions for the iterative shift-subtract divider:
// state encodings, cycle count helper and the divide-by-zero result fill.
package md_iter_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int DATA_WIDTH = 32;

  function automatic int div_cycles(input int width);
    return width + 1;
  endfunction

  localparam int DIV_CYCLES = div_cycles(DATA_WIDTH);

  // A zero divisor yields an all-ones quotient regardless of signedness.
  localparam logic DBZ_Q_FILL = 1'b1;

endpackage

// File: rtl/md_iter_divider.sv
// Multicycle restoring divider: one quotient bit per cycle on magnitudes,
// signs applied in a single fix-up cycle before the done pulse.
module md_iter_divider
  import md_iter_divider_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(div_cycles(WIDTH));

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             done_q, done_d;

  logic             accept;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign accept = (state_q == IDLE) && start && !cancel;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (cancel)                         state_d = IDLE;
        else if (count_q == CNT_W'(1))      state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The trial subtract is one bit wider than the operands so the borrow
  // shows up as a sign bit, which keeps |most negative| representable.
  always_comb begin
    dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dsr_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    shifted = {rem_q, acc_q[WIDTH-1]};
    trial   = shifted - {1'b0, dsr_q};
    quo_fix = dbz_q ? {WIDTH{DBZ_Q_FILL}} : (quo_neg_q ? -acc_q : acc_q);
    rem_fix = dbz_q ? raw_q : (rem_neg_q ? -rem_q : rem_q);
  end

  always_comb begin
    count_d       = count_q;
    rem_d         = rem_q;
    acc_d         = acc_q;
    dsr_d         = dsr_q;
    raw_d         = raw_q;
    quo_neg_d     = quo_neg_q;
    rem_neg_d     = rem_neg_q;
    dbz_d         = dbz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    done_d        = 1'b0;
    if (accept) begin
      count_d   = CNT_W'(WIDTH);
      rem_d     = '0;
      acc_d     = dvd_mag;
      dsr_d     = dsr_mag;
      raw_d     = dividend;
      quo_neg_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      rem_neg_d = is_signed && dividend[WIDTH-1];
      dbz_d     = (divisor == '0);
    end else if (state_q == RUN && !cancel) begin
      count_d = count_q - CNT_W'(1);
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        acc_d = {acc_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        acc_d = {acc_q[WIDTH-2:0], 1'b0};
      end
    end else if (state_q == FIX && !cancel) begin
      quotient_d    = quo_fix;
      remainder_d   = rem_fix;
      div_by_zero_d = dbz_q;
      done_d        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= '0;
      rem_q         <= '0;
      acc_q         <= '0;
      dsr_q         <= '0;
      raw_q         <= '0;
      quo_neg_q     <= 1'b0;
      rem_neg_q     <= 1'b0;
      dbz_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      count_q       <= count_d;
      rem_q         <= rem_d;
      acc_q         <= acc_d;
      dsr_q         <= dsr_d;
      raw_q         <= raw_d;
      quo_neg_q     <= quo_neg_d;
      rem_neg_q     <= rem_neg_d;
      dbz_q         <= dbz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    busy        = (state_q == RUN) || (state_q == FIX);
    done        = done_q;
    quotient    = quotient_q;
    remainder   = remainder_q;
    div_by_zero = div_by_zero_q;
  end

endmodule

// File: tb/tb_md_iter_divider.sv
// Self-checking bench for md_iter_divider: directed vectors, randomized ops
// against an arithmetic reference, cancel/reset aborts and handshake cases.
module tb_md_iter_divider;
  import md_iter_divider_pkg::*;

  localparam int W   = 32;
  localparam int LAT = DIV_CYCLES + 1;

  logic         clk = 1'b0;
  logic         reset, start, is_signed, cancel;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         s;
    logic [W-1:0] a, b, q, r;
    logic         z;
  } vec_t;

  md_iter_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .cancel(cancel),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero
  // and % follows the dividend sign, matching DIV/DIVU semantics.
  function automatic void ref_div(input logic s, input logic [W-1:0] a, b,
                                  output logic [W-1:0] q, r, output logic z);
    longint sa, sb;
    longint unsigned ua, ub;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      q = W'(sa / sb); r = W'(sa % sb); z = 1'b0;
    end else begin
      ua = {32'b0, a}; ub = {32'b0, b};
      q = W'(ua / ub); r = W'(ua % ub); z = 1'b0;
    end
  endfunction

  task automatic issue(input logic s, input logic [W-1:0] a, b);
    is_signed = s; dividend = a; divisor = b; start = 1'b1;
  endtask

  // Leaves the bench sitting in the done cycle (or after the bound expires).
  task automatic wait_done(output int lat, output int busy_cycles);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_cycles = 0;
    for (int i = 1; i <= LAT + 20; i++) begin
      if (busy) busy_cycles++;
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; cancel = 1'b1;
    is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0; cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (quotient !== '0) begin errors++; $display("[TB] FAIL reset_quotient got %h want 0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("[TB] FAIL reset_remainder got %h want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz got %b want 0", div_by_zero); end
  endtask

  task automatic test_directed();
    vec_t v [10];
    int lat, bc;
    v[0] = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    v[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
    v[2] = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0};
    v[3] = '{1'b0, 32'hFFFFFFF9,  32'd2,         32'h7FFFFFFC,  32'd1,         1'b0};
    v[4] = '{1'b1, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1};
    v[5] = '{1'b1, 32'd9,         32'd3,         32'd3,         32'd0,         1'b0};
    v[6] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
    v[7] = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0};
    v[8] = '{1'b0, 32'h00001234,  32'd0,         32'hFFFFFFFF,  32'h00001234,  1'b1};
    v[9] = '{1'b1, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFF9,  1'b1};
    for (int k = 0; k < 10; k++) begin
      issue(v[k].s, v[k].a, v[k].b);
      wait_done(lat, bc);
      checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL dir%0d_latency got %0d want %0d", k, lat, LAT); end
      checks++; if (bc !== DIV_CYCLES) begin errors++; $display("[TB] FAIL dir%0d_busy_cycles got %0d want %0d", k, bc, DIV_CYCLES); end
      checks++; if (quotient !== v[k].q) begin errors++; $display("[TB] FAIL dir%0d_quotient got %h want %h", k, quotient, v[k].q); end
      checks++; if (remainder !== v[k].r) begin errors++; $display("[TB] FAIL dir%0d_remainder got %h want %h", k, remainder, v[k].r); end
      checks++; if (div_by_zero !== v[k].z) begin errors++; $display("[TB] FAIL dir%0d_dbz got %b want %b", k, div_by_zero, v[k].z); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_done_pulse got %b want 0", k, done); end
    end
  endtask

  task automatic test_random();
    logic         s;
    logic [W-1:0] a, b, eq, er;
    logic         ez;
    int lat, bc;
    for (int k = 0; k < 30; k++) begin
      s = 1'($urandom_range(0, 1));
      a = (k % 7 == 3) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      ref_div(s, a, b, eq, er, ez);
      issue(s, a, b);
      wait_done(lat, bc);
      checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL rnd%0d_latency got %0d want %0d", k, lat, LAT); end
      checks++; if (quotient !== eq) begin errors++; $display("[TB] FAIL rnd%0d_quotient s=%b %h/%h got %h want %h", k, s, a, b, quotient, eq); end
      checks++; if (remainder !== er) begin errors++; $display("[TB] FAIL rnd%0d_remainder s=%b %h/%h got %h want %h", k, s, a, b, remainder, er); end
      checks++; if (div_by_zero !== ez) begin errors++; $display("[TB] FAIL rnd%0d_dbz got %b want %b", k, div_by_zero, ez); end
    end
  endtask

  task automatic test_cancel();
    int lat, bc, seen;
    issue(1'b0, 32'd100, 32'd7);
    wait_done(lat, bc);
    checks++; if (quotient !== 32'd14) begin errors++; $display("[TB] FAIL cancel_setup_quotient got %h want %h", quotient, 32'd14); end
    // Abort at RUN step 10.
    issue(1'b0, 32'd50, 32'd5);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cancel_run_busy got %b want 0", busy); end
    seen = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL cancel_run_done got %0d pulses want 0", seen); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("[TB] FAIL cancel_run_quotient got %h want %h", quotient, 32'd14); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("[TB] FAIL cancel_run_remainder got %h want %h", remainder, 32'd2); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL cancel_run_dbz got %b want 0", div_by_zero); end
    // Abort while in FIX (sampled at E33).
    issue(1'b0, 32'd20, 32'd6);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cancel_fix_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL cancel_fix_done got %b want 0", done); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("[TB] FAIL cancel_fix_quotient got %h want %h", quotient, 32'd14); end
    // start together with cancel in IDLE is dropped.
    issue(1'b0, 32'd9, 32'd3);
    cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cancel_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_abort();
    int lat, bc, seen;
    issue(1'b0, 32'd100, 32'd7);
    wait_done(lat, bc);
    issue(1'b0, 32'd50, 32'd5);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstabort_busy got %b want 0", busy); end
    checks++; if (quotient !== '0) begin errors++; $display("[TB] FAIL rstabort_quotient got %h want 0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("[TB] FAIL rstabort_remainder got %h want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL rstabort_dbz got %b want 0", div_by_zero); end
    seen = 0;
    for (int i = 0; i < LAT + 5; i++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL rstabort_done got %0d pulses want 0", seen); end
  endtask

  task automatic test_busy_start();
    logic [W-1:0] eq, er;
    logic         ez;
    int lat;
    ref_div(1'b1, 32'hFFFFFF9C, 32'd7, eq, er, ez);
    issue(1'b1, 32'hFFFFFF9C, 32'd7);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= LAT + 20; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (i % 5 == 0 && i <= DIV_CYCLES) begin
        issue(1'($urandom_range(0, 1)), $urandom, 32'($urandom_range(1, 99)));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL busystart_latency got %0d want %0d", lat, LAT); end
    checks++; if (quotient !== eq) begin errors++; $display("[TB] FAIL busystart_quotient got %h want %h", quotient, eq); end
    checks++; if (remainder !== er) begin errors++; $display("[TB] FAIL busystart_remainder got %h want %h", remainder, er); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    issue(1'b0, 32'd100, 32'd7);
    wait_done(lat, bc);
    checks++; if (quotient !== 32'd14) begin errors++; $display("[TB] FAIL b2b_first_quotient got %h want %h", quotient, 32'd14); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("[TB] FAIL b2b_first_remainder got %h want %h", remainder, 32'd2); end
    issue(1'b0, 32'd20, 32'd6);
    wait_done(lat, bc);
    checks++; if (lat !== LAT) begin errors++; $display("[TB] FAIL b2b_second_latency got %0d want %0d", lat, LAT); end
    checks++; if (bc !== DIV_CYCLES) begin errors++; $display("[TB] FAIL b2b_second_busy got %0d want %0d", bc, DIV_CYCLES); end
    checks++; if (quotient !== 32'd3) begin errors++; $display("[TB] FAIL b2b_second_quotient got %h want %h", quotient, 32'd3); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("[TB] FAIL b2b_second_remainder got %h want %h", remainder, 32'd2); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cancel = 1'b0;
    is_signed = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_directed();
    test_random();
    test_cancel();
    test_reset_abort();
    test_busy_start();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
